player_key_decoder: RTL and testbench
=====================================

// Module: player_key_decoder
// PURPOSE
//  Converts PS/2 set-2 scancode bytes from the PS/2 byte receiver into held-key levels
//  left/right/jump and a one-shot reset request for player_move_ctrl.
//  Tracks make/break and E0 prefixes. One instance per player; key bindings set by parameters.
// PARAMETERS
//  KEY_LEFT        8'h1C      make code for left (A)
//  KEY_RIGHT       8'h23      make code for right (D)
//  KEY_JUMP        8'h1D      make code for jump (W)
//  KEY_RESET       8'h2D      make code for reset request (R)
//  PREFIX_TIMEOUT  2_000_000  clk cycles a prefix state may wait for its next byte
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous, active-high reset
//  rx_data    in   8  scancode byte from PS/2 receiver
//  rx_valid   in   1  one-cycle strobe, rx_data valid
//  left       out  1  left key held
//  right      out  1  right key held
//  jump       out  1  jump key held
//  reset_req  out  1  one-cycle pulse on reset-key press
// BEHAVIOUR
//  - Reset: state IDLE; left=right=jump=reset_req=0; timeout counter=0; reset_held=0.
//  - FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
//  - IDLE: E0->EXT; F0->BRK; other byte = make code, set matching key, stay IDLE.
//  - EXT: F0->EXT_BRK; other byte = extended make, apply, ->IDLE.
//  - BRK: byte = break code, clear matching key, ->IDLE.
//  - EXT_BRK: byte = extended break, clear matching key, ->IDLE.
//  - Unmapped codes are consumed without effect; state still returns to IDLE.
//  - Output latency: key level changes on the clk edge after the rx_valid of the final byte.
//  - Typematic repeats (repeated make while held): level stays 1, no other effect.
//  - reset_req: 1 for exactly one cycle on the KEY_RESET make when reset_held=0.
//    Sets reset_held; the KEY_RESET break clears it. Repeats give no further pulse.
//  - Byte AA (BAT/hot-plug) in any state: clear all key levels and reset_held, ->IDLE.
//  - Byte FA (ack) or FE (resend) in IDLE: ignored.
//  - Prefix timeout: in EXT/BRK/EXT_BRK the counter runs each cycle without rx_valid.
//    At PREFIX_TIMEOUT-1: ->IDLE, counter=0, key levels unchanged.
//    Counter clears on every rx_valid and whenever the state is IDLE.
//  - Left and right held together: both outputs 1 (arbitration belongs to player_move_ctrl).
//  - rst mid-sequence: behaves as reset above; following break byte is treated as make in IDLE.
// CONFIGURATION
//  ARROW_KEYS_EN defined: extended codes E0 6B/E0 74/E0 75 also drive left/right/jump.
//    Each output is the OR of an independent letter-key bit and arrow-key bit.
//    Releasing one source keeps the output high while the other is held.
//  ARROW_KEYS_EN undefined: extended make/break are consumed and ignored.
//    No arrow-key state registers are built.
// STRUCTURE
//  - game_pkg: scancode constants (PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_BAT=8'hAA,
//    PS2_ACK=8'hFA, PS2_RESEND=8'hFE, arrow codes) and the 2-bit decoder state enum.
//  - No sub-module. FSM, timeout counter and key registers all live in this file.
//  - Registered outputs, comb next-state block, safe sync-reset style.
// TESTING
//  1 Bytes 1C, 1C, F0 1C -> left=1 one cycle after first 1C; stays 1; 0 after final 1C.
//  2 Bytes 2D, 2D, 2D, F0 2D, 2D -> exactly two reset_req pulses, 1 cycle each
//    (first 2D, last 2D).
//  3 Hold 1C and 23, then byte AA -> left=right=1, then both 0 the cycle after AA.
//    State IDLE.
//  4 Byte F0, then PREFIX_TIMEOUT idle cycles, then 1D -> timeout to IDLE.
//    1D treated as make: jump=1.
//  5 ARROW_KEYS_EN: E0 6B, 1C, F0 1C -> left stays 1.
//    E0 F0 6B -> left=0. Without macro: E0 6B leaves left=0.
//  6 rst asserted between F0 and 23 while right=1 -> right=0.
//    Next 23 sets right=1 again (state was IDLE).

Source files
------------

// File: rtl/game_pkg.sv
// Scancode constants, decoder state encoding and key-match helper shared by the player input logic.
package game_pkg;

    localparam logic [7:0] PS2_EXT     = 8'hE0;
    localparam logic [7:0] PS2_BRK     = 8'hF0;
    localparam logic [7:0] PS2_BAT     = 8'hAA;
    localparam logic [7:0] PS2_ACK     = 8'hFA;
    localparam logic [7:0] PS2_RESEND  = 8'hFE;
    localparam logic [7:0] ARROW_LEFT  = 8'h6B;
    localparam logic [7:0] ARROW_RIGHT = 8'h74;
    localparam logic [7:0] ARROW_UP    = 8'h75;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    // One-hot match of a code against a binding; bit0 left, bit1 right, bit2 jump.
    function automatic logic [2:0] key_mask(input logic [7:0] code,
                                            input logic [7:0] k_left,
                                            input logic [7:0] k_right,
                                            input logic [7:0] k_jump);
        key_mask = {code == k_jump, code == k_right, code == k_left};
    endfunction

endpackage

// File: rtl/player_key_decoder.sv
// PS/2 set-2 scancode to held-key levels (left/right/jump) plus a one-shot reset request.
// Optional ARROW_KEYS_EN: E0 6B/74/75 arrows also drive left/right/jump via separate state bits.
module player_key_decoder
    import game_pkg::*;
#(
    parameter logic [7:0]  KEY_LEFT       = 8'h1C,
    parameter logic [7:0]  KEY_RIGHT      = 8'h23,
    parameter logic [7:0]  KEY_JUMP       = 8'h1D,
    parameter logic [7:0]  KEY_RESET      = 8'h2D,
    parameter int unsigned PREFIX_TIMEOUT = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       left,
    output logic       right,
    output logic       jump,
    output logic       reset_req
);

    localparam int CNT_W = ($clog2(PREFIX_TIMEOUT) > 0) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

    dec_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       letter_q, letter_d;
    logic             held_q, held_d;
    logic             req_d;
    logic [2:0]       key_nxt;
    logic [2:0]       letter_mask;

    assign letter_mask = key_mask(rx_data, KEY_LEFT, KEY_RIGHT, KEY_JUMP);

`ifdef ARROW_KEYS_EN
    logic [2:0] arrow_q, arrow_d;
    logic [2:0] arrow_mask;
    assign arrow_mask = key_mask(rx_data, ARROW_LEFT, ARROW_RIGHT, ARROW_UP);
    assign key_nxt    = letter_d | arrow_d;
`else
    assign key_nxt    = letter_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        letter_d = letter_q;
        held_d   = held_q;
        req_d    = 1'b0;
`ifdef ARROW_KEYS_EN
        arrow_d  = arrow_q;
`endif
        if (rx_valid) begin
            if (rx_data == PS2_BAT) begin
                // Keyboard hot-plug: forget everything held.
                letter_d = '0;
                held_d   = 1'b0;
                state_d  = ST_IDLE;
`ifdef ARROW_KEYS_EN
                arrow_d  = '0;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_data == PS2_EXT) begin
                            state_d = ST_EXT;
                        end else if (rx_data == PS2_BRK) begin
                            state_d = ST_BRK;
                        end else if (rx_data != PS2_ACK && rx_data != PS2_RESEND) begin
                            letter_d = letter_q | letter_mask;
                            if (rx_data == KEY_RESET && !held_q) begin
                                req_d  = 1'b1;
                                held_d = 1'b1;
                            end
                        end
                    end
                    ST_EXT: begin
                        if (rx_data == PS2_BRK) begin
                            state_d = ST_EXT_BRK;
                        end else begin
`ifdef ARROW_KEYS_EN
                            arrow_d = arrow_q | arrow_mask;
`endif
                            state_d = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        letter_d = letter_q & ~letter_mask;
                        if (rx_data == KEY_RESET) held_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                    default: begin
`ifdef ARROW_KEYS_EN
                        arrow_d = arrow_q & ~arrow_mask;
`endif
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end else if (state_q != ST_IDLE) begin
            // A stalled prefix is abandoned so a lost byte cannot wedge the decoder.
            if (cnt_q == CNT_LAST) state_d = ST_IDLE;
            else                   cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            letter_q  <= '0;
            held_q    <= 1'b0;
            left      <= 1'b0;
            right     <= 1'b0;
            jump      <= 1'b0;
            reset_req <= 1'b0;
`ifdef ARROW_KEYS_EN
            arrow_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            letter_q  <= letter_d;
            held_q    <= held_d;
            left      <= key_nxt[0];
            right     <= key_nxt[1];
            jump      <= key_nxt[2];
            reset_req <= req_d;
`ifdef ARROW_KEYS_EN
            arrow_q   <= arrow_d;
`endif
        end
    end

endmodule

// File: tb/tb_player_key_decoder.sv
// Self-checking bench for player_key_decoder: constant vector table, directed corner cases, random bytes vs. a key-set model.
module tb_player_key_decoder;

    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       left, right, jump, reset_req;

    int compared = 0;
    int mismatched = 0;

    player_key_decoder #(.PREFIX_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .left(left), .right(right), .jump(jump), .reset_req(reset_req)
    );

    always #5 clk = ~clk;

    // Model: pending-prefix flags, idle cycles waited, sets of held keys per source.
    bit       m_ext, m_brk, m_held, m_req;
    int       m_wait;
    bit [2:0] m_letter, m_arrow;

    function automatic int letter_idx(input logic [7:0] b);
        case (b)
            8'h1C:   return 0;
            8'h23:   return 1;
            8'h1D:   return 2;
            default: return -1;
        endcase
    endfunction

    function automatic int arrow_idx(input logic [7:0] b);
`ifdef ARROW_KEYS_EN
        case (b)
            8'h6B:   return 0;
            8'h74:   return 1;
            8'h75:   return 2;
            default: return -1;
        endcase
`else
        return -1;
`endif
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_held = 0; m_req = 0; m_wait = 0;
        m_letter = '0; m_arrow = '0;
    endtask

    task automatic model_apply(input bit v, input logic [7:0] b);
        int k;
        m_req = 0;
        if (v) begin
            m_wait = 0;
            if (b == 8'hAA) begin
                m_letter = '0; m_arrow = '0; m_held = 0; m_ext = 0; m_brk = 0;
            end else if (!m_ext && !m_brk) begin
                if (b == 8'hE0) m_ext = 1;
                else if (b == 8'hF0) m_brk = 1;
                else if (b != 8'hFA && b != 8'hFE) begin
                    k = letter_idx(b);
                    if (k >= 0) m_letter[k] = 1;
                    if (b == 8'h2D && !m_held) begin m_req = 1; m_held = 1; end
                end
            end else if (m_ext && !m_brk) begin
                if (b == 8'hF0) m_brk = 1;
                else begin
                    k = arrow_idx(b);
                    if (k >= 0) m_arrow[k] = 1;
                    m_ext = 0;
                end
            end else begin
                if (m_ext) begin
                    k = arrow_idx(b);
                    if (k >= 0) m_arrow[k] = 0;
                end else begin
                    k = letter_idx(b);
                    if (k >= 0) m_letter[k] = 0;
                    if (b == 8'h2D) m_held = 0;
                end
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_wait++;
            if (m_wait == T) begin m_ext = 0; m_brk = 0; m_wait = 0; end
        end
    endtask

    function automatic logic [3:0] model_out();
        bit [2:0] h;
        h = m_letter | m_arrow;
        return {h[0], h[1], h[2], m_req};
    endfunction

    function automatic logic [3:0] dut_out();
        return {left, right, jump, reset_req};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got lrjq=%b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input bit v, input logic [7:0] b);
        rx_valid = v;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        model_apply(v, b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit         v;
        logic [7:0] d;
        logic [3:0] exp;   // {left,right,jump,reset_req}
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit v, input logic [7:0] d, input logic [3:0] e);
        vec_t x;
        x.v = v; x.d = d; x.exp = e;
        tbl.push_back(x);
    endtask

    initial begin
        logic [7:0] pool [12];
        logic [3:0] arrow_exp;

        // make/typematic/break of left
        add(1, 8'h1C, 4'b1000); add(0, 8'h00, 4'b1000); add(1, 8'h1C, 4'b1000);
        add(1, 8'hF0, 4'b1000); add(1, 8'h1C, 4'b0000);
        // reset key: pulse only on first press after release
        add(1, 8'h2D, 4'b0001); add(1, 8'h2D, 4'b0000); add(1, 8'h2D, 4'b0000);
        add(1, 8'hF0, 4'b0000); add(1, 8'h2D, 4'b0000); add(1, 8'h2D, 4'b0001);
        add(0, 8'h00, 4'b0000); add(1, 8'hF0, 4'b0000); add(1, 8'h2D, 4'b0000);
        // left+right together, then BAT clears both; next byte is a make
        add(1, 8'h1C, 4'b1000); add(1, 8'h23, 4'b1100); add(1, 8'hAA, 4'b0000);
        add(1, 8'h1D, 4'b0010); add(1, 8'hF0, 4'b0010); add(1, 8'h1D, 4'b0000);
        // ack/resend ignored in IDLE
        add(1, 8'hFA, 4'b0000); add(1, 8'h1C, 4'b1000); add(1, 8'hFE, 4'b1000);
        // unmapped break consumed, decoder back in IDLE
        add(1, 8'hF0, 4'b1000); add(1, 8'h55, 4'b1000); add(1, 8'h23, 4'b1100);
        add(1, 8'hF0, 4'b1100); add(1, 8'h23, 4'b1000); add(1, 8'hF0, 4'b1000);
        add(1, 8'h1C, 4'b0000);
        // extended form of a letter code is not a letter press
        add(1, 8'hE0, 4'b0000); add(1, 8'h1C, 4'b0000); add(1, 8'h1C, 4'b1000);
        // BAT while in break-prefix state
        add(1, 8'hF0, 4'b1000); add(1, 8'hAA, 4'b0000); add(1, 8'h1C, 4'b1000);
        add(1, 8'hF0, 4'b1000); add(1, 8'h1C, 4'b0000);

        do_reset();
        check("reset_state", dut_out(), 4'b0000);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d);
            check($sformatf("table[%0d]", i), dut_out(), tbl[i].exp);
        end

        // Prefix held one cycle short of timeout: byte is still a break.
        step(1, 8'h1D); check("jump_make", dut_out(), 4'b0010);
        step(1, 8'hF0);
        for (int i = 0; i < T - 1; i++) step(0, 8'h00);
        check("pre_timeout_hold", dut_out(), 4'b0010);
        step(1, 8'h1D); check("break_before_timeout", dut_out(), 4'b0000);

        // Full timeout: F0 abandoned, 1D is a make; held left unaffected.
        step(1, 8'h1C);
        step(1, 8'hF0);
        for (int i = 0; i < T; i++) step(0, 8'h00);
        check("timeout_keeps_levels", dut_out(), 4'b1000);
        step(1, 8'h1D); check("make_after_timeout", dut_out(), 4'b1010);
        step(1, 8'hF0); step(1, 8'h1D); step(1, 8'hF0); step(1, 8'h1C);
        check("timeout_cleanup", dut_out(), 4'b0000);

        // Arrow and letter sources for left are independent.
`ifdef ARROW_KEYS_EN
        arrow_exp = 4'b1000;
`else
        arrow_exp = 4'b0000;
`endif
        step(1, 8'hE0); step(1, 8'h6B); check("arrow_make", dut_out(), arrow_exp);
        step(1, 8'h1C); check("arrow_plus_letter", dut_out(), 4'b1000);
        step(1, 8'hF0); step(1, 8'h1C); check("letter_release", dut_out(), arrow_exp);
        step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h6B);
        check("arrow_release", dut_out(), 4'b0000);

        // rst between F0 and 23 drops right; following 23 is a make.
        step(1, 8'h23); check("right_make", dut_out(), 4'b0100);
        step(1, 8'hF0);
        do_reset();
        check("rst_mid_seq", dut_out(), 4'b0000);
        step(1, 8'h23); check("make_after_rst", dut_out(), 4'b0100);
        step(1, 8'hF0); step(1, 8'h23);

        // Random bytes with idle gaps long enough to reach the timeout.
        pool = '{8'h1C, 8'h23, 8'h1D, 8'h2D, 8'hE0, 8'hF0, 8'hAA,
                 8'h6B, 8'h74, 8'h75, 8'hFA, 8'h55};
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                int gap;
                gap = $urandom_range(T - 2, T + 1);
                for (int g = 0; g < gap; g++) begin
                    step(0, 8'h00);
                    check("rand_idle", dut_out(), model_out());
                end
            end else begin
                step($urandom_range(0, 1) == 1, pool[$urandom_range(0, 11)]);
                check("rand", dut_out(), model_out());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
